alu32: RTL and testbench
========================

Name: alu32

Overview:
- 32-bit registered arithmetic/compare/shift unit used as the execute-stage ALU. It is driven by the control unit's 6-bit opCode.
- Result, carry/compare bit and Z/N flags are captured on the rising clock edge. One-cycle latency.
- No handshake: a new operation may be presented every cycle.

Parameters:
- WIDTH, 32, operand/result width. All bit indices below assume 32. Shift amount uses the low log2(WIDTH) bits of B.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  synchronous active-low reset.
- A  input  32  operand A.
- B  input  32  operand B; also the shift amount for shift ops.
- opCode  input  6  operation select.
- ans1  output  32  registered primary result.
- ans2  output  1  registered secondary bit: carry, compare result or shifted-out bit.
- Z  output  1  registered zero flag: ans1 == 0.
- N  output  1  registered negative flag: ans1[31].

Behaviour:
- All outputs are registers. They update only on posedge clk.
- rst_n is sampled at posedge clk. When rst_n=0 at an edge: ans1=0, ans2=0, Z=1, N=0. Reset overrides any opCode that cycle.
- Latency: operands/opCode sampled at edge k; results are visible after edge k. Back-to-back ops have no bubbles.
- Opcodes (others are reserved):
  - 010000 ADD: ans1 = A+B mod 2^32; ans2 = carry-out of bit 31.
  - 010001 SUB: ans1 = A-B mod 2^32, computed as A + ~B + 1; ans2 = carry-out = 1 when A >= B unsigned (no borrow).
  - 100000 EQ: r = (A==B).
  - 100001 NE: r = (A!=B).
  - 100010 LE: r = ($signed(A) <= $signed(B)), two's-complement signed.
  - 100011 GT: r = ($signed(A) > $signed(B)), signed.
  - For all compare ops: ans1 = {31'b0, r}; ans2 = r.
  - 110000 SLL: ans1 = A << B[4:0]; ans2 = last bit shifted out, i.e. A[32-B[4:0]].
  - 110001 SRL: ans1 = A >> B[4:0], zero fill; ans2 = A[B[4:0]-1].
  - 110010 SRA: ans1 = A >>> B[4:0], sign fill; ans2 = A[B[4:0]-1].
- Shift amount: B[31:5] are ignored. A shift amount of 0 gives ans1=A, ans2=0.
- Reserved opCode: ans1=0, ans2=0, Z=1, N=0. No sticky error state.
- Z and N are derived from the value being written into ans1 in the same edge, so they are always consistent with ans1.
- There is no overflow output. Signed overflow is not reported.
- Operand inputs need no stability beyond setup/hold around the edge.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with opCode=010000, A=B=1 -> ans1=0, ans2=0, Z=1, N=0. Release; after the next edge -> ans1=00000002.
- ADD:
  - A=00000001, B=00000001 -> ans1=00000002, ans2=0, Z=0, N=0.
  - A=FFFFFFFF, B=FFFFFFFE -> ans1=FFFFFFFD, ans2=1, N=1.
  - A=FFFFFFFF, B=00000001 -> ans1=0, ans2=1, Z=1.
- SUB:
  - A=B=00000001 -> ans1=0, ans2=1, Z=1.
  - A=FFFFFFFF, B=FFFFFFFE -> ans1=00000001, ans2=1.
  - A=00000001, B=00000002 -> ans1=FFFFFFFF, ans2=0, N=1.
- Compare:
  - EQ, A=B=1 -> ans1=1, ans2=1, Z=0.
  - NE, same operands -> ans1=0, Z=1.
  - LE, A=FFFFFFFF, B=00000001 -> 1 (signed).
  - GT, A=00000001, B=00000002 -> 0.
  - GT, A=00000001, B=FFFFFFFE -> 1.
- Shifts:
  - SLL, A=00010000, B=1 -> 00020000, ans2=0.
  - SRL, A=FFFFFFFF, B=1 -> 7FFFFFFF, ans2=1, N=0.
  - SRA, same operands -> FFFFFFFF, ans2=1, N=1.
  - SLL, B=00000020 -> ans1=A, ans2=0 (B[4:0]=0).
- Pipelining and reserved:
  - Change opCode every cycle (ADD, SUB, EQ, SRA, reserved 000000) -> each result appears exactly one edge later.
  - Reserved opCode gives ans1=0, Z=1.
  - Assert rst_n=0 mid-sequence -> the next edge forces reset values.

Source files
------------

// File: rtl/alu32.sv
// alu32 -- registered execute-stage ALU: add/sub, compares, shifts.
//
// Every output is a register, so a result appears one clock edge after its
// operands and opCode are sampled. A new operation can be issued each cycle.
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   synchronous active-low reset
//   A       in   WIDTH  operand A
//   B       in   WIDTH  operand B; the low log2(WIDTH) bits are the shift amount
//   opCode  in   6      operation select
//   ans1    out  WIDTH  primary result
//   ans2    out  1      carry, compare result or last shifted-out bit
//   Z       out  1      ans1 == 0
//   N       out  1      ans1 MSB
module alu32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [5:0]       opCode,
  output logic [WIDTH-1:0] ans1,
  output logic             ans2,
  output logic             Z,
  output logic             N
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [5:0] OP_ADD = 6'b010000;
  localparam logic [5:0] OP_SUB = 6'b010001;
  localparam logic [5:0] OP_EQ  = 6'b100000;
  localparam logic [5:0] OP_NE  = 6'b100001;
  localparam logic [5:0] OP_LE  = 6'b100010;
  localparam logic [5:0] OP_GT  = 6'b100011;
  localparam logic [5:0] OP_SLL = 6'b110000;
  localparam logic [5:0] OP_SRL = 6'b110001;
  localparam logic [5:0] OP_SRA = 6'b110010;

  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic        [SHW-1:0]   shamt;
  logic        [WIDTH-1:0] ans1_d;
  logic                    ans2_d;
  logic                    cmp;

  logic [WIDTH-1:0] ans1_q;
  logic             ans2_q;
  logic             z_q;
  logic             n_q;

  assign a_s   = A;
  assign b_s   = B;
  assign shamt = B[SHW-1:0];

  always_comb begin
    ans1_d = '0;
    ans2_d = 1'b0;
    cmp    = 1'b0;
    unique case (opCode)
      OP_ADD: {ans2_d, ans1_d} = {1'b0, A} + {1'b0, B};
      // Carry-out of A + ~B + 1 is the "no borrow" (A >= B unsigned) bit.
      OP_SUB: {ans2_d, ans1_d} = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);
      OP_EQ, OP_NE, OP_LE, OP_GT: begin
        unique case (opCode)
          OP_EQ:   cmp = (A == B);
          OP_NE:   cmp = (A != B);
          OP_LE:   cmp = (a_s <= b_s);
          default: cmp = (a_s > b_s);
        endcase
        ans1_d = {{(WIDTH-1){1'b0}}, cmp};
        ans2_d = cmp;
      end
      // One guard bit beyond the word catches the last bit shifted out;
      // with a zero shift the guard bit stays 0.
      OP_SLL: {ans2_d, ans1_d} = {1'b0, A} << shamt;
      OP_SRL: {ans1_d, ans2_d} = {A, 1'b0} >> shamt;
      OP_SRA: {ans1_d, ans2_d} = $signed({A, 1'b0}) >>> shamt;
      default: begin
        ans1_d = '0;
        ans2_d = 1'b0;
      end
    endcase
  end

  // Output register stage: flags come from the same value loaded into ans1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ans1_q <= '0;
      ans2_q <= 1'b0;
      z_q    <= 1'b1;
      n_q    <= 1'b0;
    end else begin
      ans1_q <= ans1_d;
      ans2_q <= ans2_d;
      z_q    <= (ans1_d == '0);
      n_q    <= ans1_d[WIDTH-1];
    end
  end

  assign ans1 = ans1_q;
  assign ans2 = ans2_q;
  assign Z    = z_q;
  assign N    = n_q;

endmodule

// File: tb/tb_alu32.sv
module tb_alu32;

  localparam logic [5:0] ADD = 6'b010000;
  localparam logic [5:0] SUB = 6'b010001;
  localparam logic [5:0] EQ  = 6'b100000;
  localparam logic [5:0] NE  = 6'b100001;
  localparam logic [5:0] LE  = 6'b100010;
  localparam logic [5:0] GT  = 6'b100011;
  localparam logic [5:0] SLL = 6'b110000;
  localparam logic [5:0] SRL = 6'b110001;
  localparam logic [5:0] SRA = 6'b110010;
  localparam logic [5:0] RSV = 6'b000000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] A, B;
  logic [5:0]  opCode;
  logic [31:0] ans1;
  logic        ans2, Z, N;

  int checks = 0;
  int passed = 0;

  alu32 #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .opCode(opCode),
    .ans1(ans1), .ans2(ans2), .Z(Z), .N(N)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e1;
    logic        e2;
    logic        ez;
    logic        en;
  } vec_t;

  // Reference model written straight from the operation definitions.
  function automatic logic [34:0] model(input logic [5:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] r;
    logic        c;
    logic [63:0] w;
    int          s;
    s = int'(b[4:0]);
    r = 32'h0;
    c = 1'b0;
    case (op)
      ADD: begin w = {32'h0, a} + {32'h0, b}; r = w[31:0]; c = w[32]; end
      SUB: begin r = a - b; c = (a >= b); end
      EQ:  begin c = (a == b); r = {31'h0, c}; end
      NE:  begin c = (a != b); r = {31'h0, c}; end
      LE:  begin c = ($signed(a) <= $signed(b)); r = {31'h0, c}; end
      GT:  begin c = ($signed(a) > $signed(b)); r = {31'h0, c}; end
      SLL: begin r = a << s; c = (s == 0) ? 1'b0 : a[32 - s]; end
      SRL: begin r = a >> s; c = (s == 0) ? 1'b0 : a[s - 1]; end
      SRA: begin r = $signed(a) >>> s; c = (s == 0) ? 1'b0 : a[s - 1]; end
      default: begin r = 32'h0; c = 1'b0; end
    endcase
    return {r, c, (r == 32'h0), r[31]};
  endfunction

  task automatic check(input string name, input logic [34:0] exp);
    checks++;
    if ({ans1, ans2, Z, N} === exp) passed++;
    else $display("FAIL %s: got ans1=%h ans2=%b Z=%b N=%b, expected ans1=%h ans2=%b Z=%b N=%b",
                  name, ans1, ans2, Z, N, exp[34:3], exp[2], exp[1], exp[0]);
  endtask

  // Drive on the falling edge, let one rising edge pass, sample 1 time unit later.
  task automatic step(input logic rst, input logic [5:0] op,
                      input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    rst_n = rst; opCode = op; A = a; B = b;
    @(posedge clk);
    #1;
  endtask

  localparam logic [34:0] RST_VAL = {32'h0, 1'b0, 1'b1, 1'b0};

  vec_t vecs[$];
  logic [34:0] prev;

  initial begin
    rst_n = 1'b0; opCode = ADD; A = 32'h1; B = 32'h1;

    vecs = '{
      '{"add_1_1",     ADD, 32'h00000001, 32'h00000001, 32'h00000002, 0, 0, 0},
      '{"add_neg",     ADD, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFD, 1, 0, 1},
      '{"add_wrap",    ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 1, 0},
      '{"sub_eq",      SUB, 32'h00000001, 32'h00000001, 32'h00000000, 1, 1, 0},
      '{"sub_big",     SUB, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1, 0, 0},
      '{"sub_borrow",  SUB, 32'h00000001, 32'h00000002, 32'hFFFFFFFF, 0, 0, 1},
      '{"eq_true",     EQ,  32'h00000001, 32'h00000001, 32'h00000001, 1, 0, 0},
      '{"ne_false",    NE,  32'h00000001, 32'h00000001, 32'h00000000, 0, 1, 0},
      '{"le_signed",   LE,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1, 0, 0},
      '{"le_equal",    LE,  32'h00000005, 32'h00000005, 32'h00000001, 1, 0, 0},
      '{"gt_false",    GT,  32'h00000001, 32'h00000002, 32'h00000000, 0, 1, 0},
      '{"gt_signed",   GT,  32'h00000001, 32'hFFFFFFFE, 32'h00000001, 1, 0, 0},
      '{"sll_1",       SLL, 32'h00010000, 32'h00000001, 32'h00020000, 0, 0, 0},
      '{"srl_1",       SRL, 32'hFFFFFFFF, 32'h00000001, 32'h7FFFFFFF, 1, 0, 0},
      '{"sra_1",       SRA, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 1, 0, 1},
      '{"sll_amt32",   SLL, 32'h00010000, 32'h00000020, 32'h00010000, 0, 0, 0},
      '{"sll_31_out1", SLL, 32'h00000003, 32'h0000001F, 32'h80000000, 1, 0, 1},
      '{"srl_31",      SRL, 32'h80000000, 32'h0000001F, 32'h00000001, 0, 0, 0},
      '{"sra_4",       SRA, 32'h80000008, 32'hFFFFFFE4, 32'hF8000000, 1, 0, 1},
      '{"reserved",    RSV, 32'h00000005, 32'h00000006, 32'h00000000, 0, 1, 0}
    };

    // Reset held for two edges with an ADD pending.
    step(1'b0, ADD, 32'h1, 32'h1); check("reset_edge1", RST_VAL);
    step(1'b0, ADD, 32'h1, 32'h1); check("reset_edge2", RST_VAL);
    step(1'b1, ADD, 32'h1, 32'h1); check("reset_release", {32'h2, 1'b0, 1'b0, 1'b0});

    // Directed table.
    foreach (vecs[i]) begin
      step(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      check(vecs[i].name, {vecs[i].e1, vecs[i].e2, vecs[i].ez, vecs[i].en});
    end

    // Back-to-back ops: output holds the previous result until the edge.
    prev = {32'h2, 1'b0, 1'b0, 1'b0};
    step(1'b1, ADD, 32'h1, 32'h1);
    begin
      logic [5:0]  ops[5] = '{ADD, SUB, EQ, SRA, RSV};
      logic [31:0] as[5]  = '{32'h7, 32'h3, 32'h9, 32'h80000000, 32'h1234};
      logic [31:0] bs[5]  = '{32'h8, 32'h5, 32'h9, 32'h00000003, 32'h5678};
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        opCode = ops[i]; A = as[i]; B = bs[i];
        #1 check($sformatf("pipe_hold%0d", i), prev);
        @(posedge clk);
        #1 check($sformatf("pipe_res%0d", i), model(ops[i], as[i], bs[i]));
        prev = model(ops[i], as[i], bs[i]);
      end
    end

    // Reset asserted mid-sequence overrides the pending op.
    step(1'b1, ADD, 32'hFFFFFFFF, 32'hFFFFFFFE); check("mid_pre", model(ADD, 32'hFFFFFFFF, 32'hFFFFFFFE));
    step(1'b0, SUB, 32'h1, 32'h2);               check("mid_reset", RST_VAL);
    step(1'b1, SUB, 32'h1, 32'h2);               check("mid_after", model(SUB, 32'h1, 32'h2));

    // Randomized traffic against the model.
    begin
      logic [5:0] oplist[10] = '{ADD, SUB, EQ, NE, LE, GT, SLL, SRL, SRA, RSV};
      for (int i = 0; i < 400; i++) begin
        logic [5:0]  op;
        logic [31:0] a, b;
        op = oplist[$urandom_range(9)];
        a  = $urandom;
        b  = ($urandom_range(3) == 0) ? a : $urandom;
        if ($urandom_range(7) == 0) op = 6'($urandom);
        step(1'b1, op, a, b);
        check($sformatf("rand%0d_op%b", i, op), model(op, a, b));
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
